// File: rtl/pixel_layer_ctrl_pkg.sv
// Shared types and constants for pixel_layer_ctrl: FSM states, config register
// addresses, priority modes, layer encodings and reset colours.
package pixel_layer_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StCommit  = 2'd2
  } state_e;

  // Config register addresses; 5-7 are accepted but ignored.
  localparam logic [2:0] CfgAddrBall = 3'd0;
  localparam logic [2:0] CfgAddrMaze = 3'd1;
  localparam logic [2:0] CfgAddrAi   = 3'd2;
  localparam logic [2:0] CfgAddrBg   = 3'd3;
  localparam logic [2:0] CfgAddrCtrl = 3'd4;

  // prio_mode encodings, named highest priority first.
  localparam logic [1:0] PrioBallAiMaze = 2'd0;
  localparam logic [1:0] PrioAiBallMaze = 2'd1;
  localparam logic [1:0] PrioMazeBallAi = 2'd2;
  localparam logic [1:0] PrioBallMazeAi = 2'd3;

  // pix_layer encodings.
  localparam logic [1:0] LayerBg   = 2'd0;
  localparam logic [1:0] LayerMaze = 2'd1;
  localparam logic [1:0] LayerBall = 2'd2;
  localparam logic [1:0] LayerAi   = 2'd3;

  // Reset colours {R, G, B}.
  localparam logic [23:0] RstBall = 24'hFFFFFF;
  localparam logic [23:0] RstMaze = 24'hFFFFFF;
  localparam logic [23:0] RstAi   = 24'hFF0000;
  localparam logic [23:0] RstBg   = 24'h3F007F;

  // One full register set; used for both shadow and active copies.
  typedef struct packed {
    logic [23:0] ball;
    logic [23:0] maze;
    logic [23:0] ai;
    logic [23:0] bg;
    logic        blink_en;
    logic [1:0]  prio;
  } cfg_set_t;

  localparam cfg_set_t CfgReset = '{
    ball:     RstBall,
    maze:     RstMaze,
    ai:       RstAi,
    bg:       RstBg,
    blink_en: 1'b0,
    prio:     PrioBallAiMaze
  };

endpackage

// File: rtl/pixel_layer_ctrl_if.sv
// Config write channel for pixel_layer_ctrl.
//   cfg_valid  write request          cfg_ready  write accepted when both high
//   cfg_addr   register select (3b)   cfg_data   {R, G, B} or control bits
interface pixel_layer_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_addr;
  logic [23:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/layer_priority_mux.sv
// Combinational layer resolution: picks the winning layer from the hit flags
// according to prio_mode and produces its colour. Background blue fades with X.
//   i_ball/i_maze/i_ai  hit flags (ball already blink-masked)
//   i_xs                DrawX[9:3]
//   i_cfg               register set latched with this pixel
//   o_rgb, o_layer      resulting colour and layer code
module layer_priority_mux
  import pixel_layer_ctrl_pkg::*;
(
  input  logic        i_ball,
  input  logic        i_maze,
  input  logic        i_ai,
  input  logic [6:0]  i_xs,
  input  cfg_set_t    i_cfg,
  output logic [23:0] o_rgb,
  output logic [1:0]  o_layer
);

  logic [7:0] w_bg_b;
  logic [1:0] w_layer;

  // Saturating subtract so the blue gradient clamps at zero.
  always_comb begin
    w_bg_b = 8'h00;
    if (i_cfg.bg[7:0] > {1'b0, i_xs}) begin
      w_bg_b = i_cfg.bg[7:0] - {1'b0, i_xs};
    end
  end

  always_comb begin
    w_layer = LayerBg;
    unique case (i_cfg.prio)
      PrioBallAiMaze: begin
        if (i_ball)      w_layer = LayerBall;
        else if (i_ai)   w_layer = LayerAi;
        else if (i_maze) w_layer = LayerMaze;
      end
      PrioAiBallMaze: begin
        if (i_ai)        w_layer = LayerAi;
        else if (i_ball) w_layer = LayerBall;
        else if (i_maze) w_layer = LayerMaze;
      end
      PrioMazeBallAi: begin
        if (i_maze)      w_layer = LayerMaze;
        else if (i_ball) w_layer = LayerBall;
        else if (i_ai)   w_layer = LayerAi;
      end
      PrioBallMazeAi: begin
        if (i_ball)      w_layer = LayerBall;
        else if (i_maze) w_layer = LayerMaze;
        else if (i_ai)   w_layer = LayerAi;
      end
      default: w_layer = LayerBg;
    endcase
  end

  always_comb begin
    o_layer = w_layer;
    o_rgb   = {i_cfg.bg[23:8], w_bg_b};
    unique case (w_layer)
      LayerMaze: o_rgb = i_cfg.maze;
      LayerBall: o_rgb = i_cfg.ball;
      LayerAi:   o_rgb = i_cfg.ai;
      default:   o_rgb = {i_cfg.bg[23:8], w_bg_b};
    endcase
  end

endmodule

// File: rtl/pixel_layer_ctrl.sv
// Pixel layer controller: double-buffered colour/priority config committed at
// frame boundaries, frame counter for ball blinking, and a 2-stage pixel
// pipeline producing registered VGA colour and the winning layer code.
//   Clk, Reset_n           clock, async active-low reset
//   frame_start            one-cycle pulse at the first pixel of a frame
//   DrawX, DrawY           pixel coordinates
//   is_ball/is_maze/is_ai  layer hit flags
//   cfg                    config write channel (slave)
//   VGA_R/G/B, pix_layer   outputs, 2 cycles after the pixel inputs
module pixel_layer_ctrl
  import pixel_layer_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_BIT = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               is_ball,
  input  logic               is_maze,
  input  logic               is_ai,
  pixel_layer_ctrl_if.slave  cfg,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B,
  output logic [1:0]         pix_layer
);

  state_e     r_state, w_state_next;
  logic       w_cfg_ready;
  logic       w_commit;
  logic       w_accept;
  logic       w_cfg_hit;
  cfg_set_t   r_shadow, r_active;
  logic [7:0] r_frame_cnt;

  logic       r_s1_ball, r_s1_maze, r_s1_ai;
  logic [6:0] r_s1_xs;
  cfg_set_t   r_s1_cfg;
  logic [23:0] w_rgb, r_rgb;
  logic [1:0]  w_layer, r_layer;

  logic w_unused;
  assign w_unused = ^{DrawY, DrawX[2:0], r_frame_cnt};

  assign w_accept  = cfg.cfg_valid & w_cfg_ready;
  assign w_cfg_hit = w_accept & (cfg.cfg_addr <= CfgAddrCtrl);
  assign cfg.cfg_ready = w_cfg_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cfg_ready  = 1'b1;
    w_commit     = 1'b0;
    unique case (r_state)
      StIdle:    if (w_cfg_hit) w_state_next = StPending;
      StPending: if (frame_start) w_state_next = StCommit;
      StCommit: begin
        w_cfg_ready  = 1'b0;
        w_commit     = 1'b1;
        w_state_next = StIdle;
      end
      default:   w_state_next = StIdle;
    endcase
  end

  // A write in the PENDING->COMMIT cycle lands in shadow before the copy.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_shadow <= CfgReset;
    end else if (w_accept) begin
      case (cfg.cfg_addr)
        CfgAddrBall: r_shadow.ball <= cfg.cfg_data;
        CfgAddrMaze: r_shadow.maze <= cfg.cfg_data;
        CfgAddrAi:   r_shadow.ai   <= cfg.cfg_data;
        CfgAddrBg:   r_shadow.bg   <= cfg.cfg_data;
        CfgAddrCtrl: begin
          r_shadow.blink_en <= cfg.cfg_data[2];
          r_shadow.prio     <= cfg.cfg_data[1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)      r_active <= CfgReset;
    else if (w_commit) r_active <= r_shadow;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         r_frame_cnt <= 8'd0;
    else if (frame_start) r_frame_cnt <= r_frame_cnt + 8'd1;
  end

  // Stage 1: hits plus a snapshot of the active set, so a commit never
  // recolours a pixel already in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_ball <= 1'b0;
      r_s1_maze <= 1'b0;
      r_s1_ai   <= 1'b0;
      r_s1_xs   <= 7'd0;
      r_s1_cfg  <= '0;
    end else begin
      r_s1_ball <= is_ball & ~(r_active.blink_en & r_frame_cnt[BLINK_BIT]);
      r_s1_maze <= is_maze;
      r_s1_ai   <= is_ai;
      r_s1_xs   <= DrawX[9:3];
      r_s1_cfg  <= r_active;
    end
  end

  layer_priority_mux u_mux (
    .i_ball  (r_s1_ball),
    .i_maze  (r_s1_maze),
    .i_ai    (r_s1_ai),
    .i_xs    (r_s1_xs),
    .i_cfg   (r_s1_cfg),
    .o_rgb   (w_rgb),
    .o_layer (w_layer)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rgb   <= 24'h000000;
      r_layer <= LayerBg;
    end else begin
      r_rgb   <= w_rgb;
      r_layer <= w_layer;
    end
  end

  assign VGA_R     = r_rgb[23:16];
  assign VGA_G     = r_rgb[15:8];
  assign VGA_B     = r_rgb[7:0];
  assign pix_layer = r_layer;

endmodule
